// File: rtl/cdc_export_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : cdc_export_arbiter_if
// Brief    : Requester bus and toggle-handshake crossing bus of cdc_export_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cdc_export_arbiter_if #(
  parameter int SIZE = 8,
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      in_valid;
  logic [NREQ*SIZE-1:0] in_data;
  logic [NREQ-1:0]      in_ready;
  logic [SIZE+IDW-1:0]  cdc_data;
  logic                 cdc_req;
  logic                 cdc_ack;
  logic                 busy;

  modport master (
    input  in_valid, in_data, cdc_ack,
    output in_ready, cdc_data, cdc_req, busy
  );

  modport slave (
    output in_valid, in_data, cdc_ack,
    input  in_ready, cdc_data, cdc_req, busy
  );
endinterface

`default_nettype wire

// File: rtl/cdc_export_arbiter.sv
//------------------------------------------------------------------------------
// Module   : cdc_export_arbiter
// Brief    : Round-robin arbiter exporting {ID, payload} words over a toggle
//            req/ack handshake. Define CDC_EXPORT_ARBITER_FIXED_PRIO_EN for
//            lowest-index-first priority instead of round-robin.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cdc_export_arbiter #(
  parameter int SIZE = 8,
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cdc_export_arbiter_if.master   bus
);

  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW   = IDW + 1;
  localparam int PADW = 1 << IDW;
  localparam logic [SW-1:0]  c_NREQ = SW'(NREQ);
  localparam logic [IDW-1:0] c_LAST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_ack_s1;
  logic                r_ack_s2;
  logic                r_req;
  logic                r_busy;
  logic [SIZE+IDW-1:0] r_data;
  logic [IDW-1:0]      r_g;
  logic [IDW-1:0]      r_rr_ptr;

  logic [PADW-1:0]     w_valid_pad;
  logic [SW-1:0]       w_sum;
  logic [IDW-1:0]      w_idx;
  logic [IDW-1:0]      w_gnt;
  logic                w_any;
  logic [SIZE-1:0]     w_sel;
  logic [NREQ-1:0]     w_ready;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_valid_pad = '0;
    w_valid_pad[NREQ-1:0] = bus.in_valid;
    w_any = 1'b0;
    w_gnt = '0;
    w_sum = '0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + SW'(k);
      if (w_sum >= c_NREQ) begin
        w_sum = w_sum - c_NREQ;
      end
      w_idx = w_sum[IDW-1:0];
      if (w_valid_pad[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  always_comb begin
    w_sel   = '0;
    w_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_sel = bus.in_data[i*SIZE +: SIZE];
        if (r_state == S_IDLE && w_any) begin
          w_ready[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
      r_req    <= 1'b0;
      r_busy   <= 1'b0;
      r_data   <= '0;
      r_g      <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_ack_s1 <= bus.cdc_ack;
      r_ack_s2 <= r_ack_s1;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_data  <= {w_gnt, w_sel};
            r_g     <= w_gnt;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end
        // cdc_data has been stable for this whole cycle before req flips.
        S_SETTLE: begin
          r_req   <= ~r_req;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_ack_s2 == r_req) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`ifdef CDC_EXPORT_ARBITER_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`else
            r_rr_ptr <= (r_g == c_LAST) ? '0 : r_g + 1'b1;
`endif
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.cdc_data = r_data;
  assign bus.cdc_req  = r_req;
  assign bus.busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_cdc_export_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_cdc_export_arbiter
// Brief    : Directed self-checking bench for cdc_export_arbiter (SIZE=8, NREQ=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cdc_export_arbiter;

  localparam int SIZE = 8;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic exp_req = 1'b0;

  always #5 clk = ~clk;

  cdc_export_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus ();

  cdc_export_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // One complete transfer with an immediately answering remote domain.
  task automatic xfer(input logic [3:0] v, input logic [31:0] d, input logic hold,
                      input logic [3:0] exp_rdy, input logic [9:0] exp_data);
    bus.in_valid = v;
    bus.in_data  = d;
    #1;
    chk("grant_ready", {28'd0, bus.in_ready}, {28'd0, exp_rdy});
    step();
    chk("cdc_data", {22'd0, bus.cdc_data}, {22'd0, exp_data});
    chk("busy_settle", {31'd0, bus.busy}, 32'd1);
    chk("ready_settle", {28'd0, bus.in_ready}, 32'd0);
    if (!hold) bus.in_valid = '0;
    step();
    exp_req = ~exp_req;
    chk("cdc_req", {31'd0, bus.cdc_req}, {31'd0, exp_req});
    bus.cdc_ack = bus.cdc_req;
    wait_idle("xfer");
  endtask

  initial begin
    logic [1:0] e;
    rst_n        = 1'b0;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.cdc_ack  = 1'b0;
    step();
    step();
    chk("reset_state", {bus.cdc_req, bus.cdc_data, bus.in_ready, bus.busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single transfer from requester 0
    bus.in_valid = 4'b0001;
    bus.in_data  = 32'h0000_00A5;
    #1;
    chk("single_ready", {28'd0, bus.in_ready}, 32'h1);
    step();
    chk("single_data", {22'd0, bus.cdc_data}, 32'h0A5);
    chk("single_req_settle", {31'd0, bus.cdc_req}, 32'd0);
    chk("single_busy", {31'd0, bus.busy}, 32'd1);
    bus.in_valid = '0;
    step();
    exp_req = 1'b1;
    chk("single_req_toggle", {31'd0, bus.cdc_req}, 32'd1);
    step();
    step();
    bus.cdc_ack = 1'b1;
    step();
    step();
    chk("single_busy_sync", {31'd0, bus.busy}, 32'd1);
    step();
    chk("single_done", {31'd0, bus.busy}, 32'd0);

    // Round-robin with all requesters held valid, from a fresh pointer
    rst_n = 1'b0;
    bus.cdc_ack = 1'b0;
    step();
    rst_n = 1'b1;
    exp_req = 1'b0;
    step();
    for (int n = 0; n < 5; n++) begin
`ifdef CDC_EXPORT_ARBITER_FIXED_PRIO_EN
      e = 2'd0;
`else
      e = 2'(n % 4);
`endif
      xfer(4'hF, 32'h1312_1110, 1'b1, 4'b0001 << e, {e, 8'(8'h10 + {6'd0, e})});
    end
    bus.in_valid = '0;
    step();

    // Slow remote: everything frozen while waiting; new request must wait
    bus.in_valid = 4'b0100;
    bus.in_data  = 32'h00C3_0000;
    #1;
    chk("slow_ready", {28'd0, bus.in_ready}, 32'h4);
    step();
    chk("slow_data", {22'd0, bus.cdc_data}, 32'h2C3);
    bus.in_valid = 4'b0001;
    bus.in_data  = 32'h0000_0066;
    step();
    exp_req = ~exp_req;
    chk("slow_req", {31'd0, bus.cdc_req}, {31'd0, exp_req});
    for (int n = 0; n < 50; n++) begin
      step();
      chk("slow_hold", {16'd0, bus.cdc_req, bus.cdc_data, bus.in_ready, bus.busy},
          {16'd0, exp_req, 10'h2C3, 4'b0000, 1'b1});
    end
    bus.cdc_ack = bus.cdc_req;
    wait_idle("slow");
    chk("wrap_ready", {28'd0, bus.in_ready}, 32'h1);
    xfer(4'b0001, 32'h0000_0066, 1'b0, 4'b0001, 10'h066);

    // Reset while waiting for the acknowledge
    bus.in_valid = 4'b1000;
    bus.in_data  = 32'h5A00_0000;
    #1;
    chk("rst_pre_ready", {28'd0, bus.in_ready}, 32'h8);
    step();
    chk("rst_pre_data", {22'd0, bus.cdc_data}, 32'h35A);
    bus.in_valid = '0;
    step();
    exp_req = ~exp_req;
    chk("rst_pre_req", {31'd0, bus.cdc_req}, {31'd0, exp_req});
    step();
    rst_n = 1'b0;
    bus.cdc_ack = 1'b0;
    #1;
    chk("rst_async", {bus.cdc_req, bus.cdc_data, bus.in_ready, bus.busy}, 32'd0);
    step();
    step();
    step();
    chk("rst_hold", {bus.cdc_req, bus.cdc_data, bus.in_ready, bus.busy}, 32'd0);
    rst_n = 1'b1;
    exp_req = 1'b0;
    step();
    chk("rst_after", {bus.cdc_req, bus.cdc_data, bus.in_ready, bus.busy}, 32'd0);
    xfer(4'b0100, 32'h0077_0000, 1'b0, 4'b0100, 10'h277);

    // Skip: requester 1 withdraws in the last WAIT cycle, requester 3 served
    bus.in_valid = 4'b0001;
    bus.in_data  = 32'h0000_0011;
    #1;
    chk("skip_pre_ready", {28'd0, bus.in_ready}, 32'h1);
    step();
    chk("skip_pre_data", {22'd0, bus.cdc_data}, 32'h011);
    bus.in_valid = 4'b1010;
    bus.in_data  = 32'h8800_2200;
    step();
    exp_req = ~exp_req;
    chk("skip_pre_req", {31'd0, bus.cdc_req}, {31'd0, exp_req});
    chk("skip_wait_ready0", {28'd0, bus.in_ready}, 32'd0);
    bus.cdc_ack = bus.cdc_req;
    step();
    chk("skip_wait_ready1", {28'd0, bus.in_ready}, 32'd0);
    step();
    chk("skip_wait_ready2", {27'd0, bus.in_ready, bus.busy}, 32'h1);
    bus.in_valid = 4'b1000;
    step();
    chk("skip_idle", {31'd0, bus.busy}, 32'd0);
    chk("skip_ready", {28'd0, bus.in_ready}, 32'h8);
    step();
    chk("skip_data", {22'd0, bus.cdc_data}, 32'h388);
    bus.in_valid = '0;
    step();
    exp_req = ~exp_req;
    chk("skip_req", {31'd0, bus.cdc_req}, {31'd0, exp_req});
    bus.cdc_ack = bus.cdc_req;
    wait_idle("skip");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cdc_export_arbiter.md
CDC_EXPORT_ARBITER -- requirements
Module: cdc_export_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 8: payload width in bits per requester.
REQ-002 SHALL have parameter NREQ, default 4: requester count, legal range 1..16.
REQ-003 SHALL have localparam IDW = max(1, clog2(NREQ)): requester-ID width.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  NREQ  bit i: requester i holds a word on in_data.
REQ-007 in_data  input  NREQ*SIZE  word of requester i at bits [i*SIZE +: SIZE].
REQ-008 in_ready  output  NREQ  one-hot pulse; word of requester i captured this edge.
REQ-009 cdc_data  output  SIZE+IDW  {ID, payload} crossing bus; stable whenever cdc_req != ack.
REQ-010 cdc_req  output  1  toggle request to the other clock domain.
REQ-011 cdc_ack  input  1  toggle acknowledge from the other domain; asynchronous to clk.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 cdc_ack SHALL pass through a 2-flop synchronizer (ack_s) before any use; no other logic reads raw cdc_ack.
REQ-014 FSM SHALL have states IDLE, SETTLE, WAIT, encoded in registers.
REQ-015 IDLE: if any in_valid is high, grant g = first valid index at or after rr_ptr (modulo NREQ), assert in_ready[g] combinationally in the same cycle, load cdc_data <= {g, in_data[g]}, go to SETTLE; else stay.
REQ-016 in_ready SHALL be zero outside IDLE and zero in IDLE when no in_valid is high; at most one bit high.
REQ-017 SETTLE: lasts exactly one cycle; at its end cdc_req <= ~cdc_req, go to WAIT (data stable >= 1 cycle before the toggle).
REQ-018 WAIT: when ack_s == cdc_req, go to IDLE and set rr_ptr <= (g+1) mod NREQ; else stay. There is no timeout.
REQ-019 cdc_data and cdc_req SHALL change only at REQ-015 and REQ-017 respectively.
REQ-020 Minimum transfer period: 1 IDLE + 1 SETTLE + WAIT (>= 2 cycles of synchronizer latency plus remote latency).
REQ-021 Requesters SHALL hold in_valid and in_data until in_ready; a requester dropping in_valid before grant is simply skipped, without error.
REQ-022 NREQ=1: ID field is 1 bit, constant 0; rr_ptr stays 0.
REQ-023 rr_ptr wrap: index NREQ-1 wraps to 0.
REQ-024 A new in_valid rising during SETTLE/WAIT SHALL be served no earlier than the next IDLE.

Reset
REQ-025 On rst_n low: state=IDLE, cdc_req=0, cdc_data=0, rr_ptr=0, g=0, synchronizer flops=0, in_ready=0, busy=0.
REQ-026 Reset mid-transfer SHALL abandon the word (no in_ready retry); the system SHALL reset the importing domain in the same event so its ack returns to 0.
REQ-027 Release of rst_n SHALL be synchronized externally to clk.

Configuration
REQ-028 Macro CDC_EXPORT_ARBITER_FIXED_PRIO_EN: defined -> grant is lowest-index valid requester, rr_ptr unused (held 0); undefined -> round-robin per REQ-015/REQ-018.

Verification
REQ-029 Single: in_valid=0001, in_data[0]=8'hA5 -> in_ready=0001 at cycle 0, cdc_data=10'h0A5, cdc_req 0->1 two edges after grant, busy until ack_s=1.
REQ-030 Round-robin: in_valid=1111 held, remote acks each toggle -> grant order 0,1,2,3,0; with FIXED_PRIO_EN -> 0,0,0.
REQ-031 Slow ack: ack delayed 50 cycles -> cdc_req and cdc_data constant, in_ready=0 throughout WAIT.
REQ-032 Reset in WAIT: rst_n low for 3 cycles -> cdc_req=0, cdc_data=0, busy=0; afterwards in_valid=0100 completes normally with ID=2.
REQ-033 Skip: in_valid=0010 drops one cycle before IDLE, in_valid=1000 high -> grant 3, no pulse on in_ready[1].
